// File: rtl/tug_of_war_field.sv
// Tug-of-war playfield: one lit position that the two players push
// left/right with button presses. Pushing it off an end wins the round for
// that player. The block keeps per-player scores, holds a round-win display,
// restarts rounds on its own and latches the match winner until reset.

module tug_of_war_field #(
  parameter int NUM_LIGHTS  = 9,
  parameter int WIN_SCORE   = 7,
  parameter int SCORE_W     = 3,
  parameter int HOLD_CYCLES = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  L,
  input  logic                  R,
  output logic [NUM_LIGHTS-1:0] leds,
  output logic [SCORE_W-1:0]    score_l,
  output logic [SCORE_W-1:0]    score_r,
  output logic                  round_win_l,
  output logic                  round_win_r,
  output logic                  match_over
);

  localparam int POS_W  = $clog2(NUM_LIGHTS);
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  localparam logic [POS_W-1:0]      POS_CENTRE   = POS_W'((NUM_LIGHTS - 1) / 2);
  localparam logic [POS_W-1:0]      POS_LEFTMOST = POS_W'(NUM_LIGHTS - 1);
  localparam logic [POS_W-1:0]      POS_RIGHTMOST = '0;
  localparam logic [SCORE_W-1:0]    SCORE_TARGET = SCORE_W'(WIN_SCORE);
  localparam logic [HOLD_W-1:0]     HOLD_LOAD    = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [NUM_LIGHTS-1:0] ALL_ONES     = '1;
  localparam logic [NUM_LIGHTS-1:0] ONE_HOT_LSB  = NUM_LIGHTS'(1);
  localparam logic [NUM_LIGHTS-1:0] LEFT_HALF    = ALL_ONES << ((NUM_LIGHTS + 1) / 2);
  localparam logic [NUM_LIGHTS-1:0] RIGHT_HALF   = ALL_ONES >> ((NUM_LIGHTS + 1) / 2);

  typedef enum logic [2:0] {
    PLAY    = 3'd0,
    WIN_L   = 3'd1,
    WIN_R   = 3'd2,
    MATCH_L = 3'd3,
    MATCH_R = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [POS_W-1:0]   pos_q, pos_d;
  logic [SCORE_W-1:0] scoreL_q, scoreL_d;
  logic [SCORE_W-1:0] scoreR_q, scoreR_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic               lPrev_q, rPrev_q;
  logic               armed_q;

  logic               pressL, pressR;
  logic [SCORE_W-1:0] scoreLInc, scoreRInc;

  // Edge registers are cleared by reset, so a button still held when reset
  // drops would look like a fresh rising edge. armed_q stays low for the
  // first clock after reset so that edge is absorbed rather than counted.
  assign pressL = armed_q & L & ~lPrev_q;
  assign pressR = armed_q & R & ~rPrev_q;

  assign scoreLInc = scoreL_q + 1'b1;
  assign scoreRInc = scoreR_q + 1'b1;

  assign score_l = scoreL_q;
  assign score_r = scoreR_q;

  // State register: all game state, edge history and the post-reset arm flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= PLAY;
      pos_q    <= POS_CENTRE;
      scoreL_q <= '0;
      scoreR_q <= '0;
      hold_q   <= '0;
      lPrev_q  <= 1'b0;
      rPrev_q  <= 1'b0;
      armed_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      scoreL_q <= scoreL_d;
      scoreR_q <= scoreR_d;
      hold_q   <= hold_d;
      lPrev_q  <= L;
      rPrev_q  <= R;
      armed_q  <= 1'b1;
    end
  end

  // Next-state logic: moves and round wins in PLAY, hold countdown in WIN_*.
  always_comb begin
    state_d  = state_q;
    pos_d    = pos_q;
    scoreL_d = scoreL_q;
    scoreR_d = scoreR_q;
    hold_d   = hold_q;

    unique case (state_q)
      PLAY: begin
        if (pressL && !pressR) begin
          if (pos_q == POS_LEFTMOST) begin
            scoreL_d = scoreLInc;
            if (scoreLInc == SCORE_TARGET) begin
              state_d = MATCH_L;
            end else begin
              state_d = WIN_L;
              hold_d  = HOLD_LOAD;
            end
          end else begin
            pos_d = pos_q + 1'b1;
          end
        end else if (pressR && !pressL) begin
          if (pos_q == POS_RIGHTMOST) begin
            scoreR_d = scoreRInc;
            if (scoreRInc == SCORE_TARGET) begin
              state_d = MATCH_R;
            end else begin
              state_d = WIN_R;
              hold_d  = HOLD_LOAD;
            end
          end else begin
            pos_d = pos_q - 1'b1;
          end
        end
      end

      WIN_L, WIN_R: begin
        if (hold_q == '0) begin
          state_d = PLAY;
          pos_d   = POS_CENTRE;
        end else begin
          hold_d = hold_q - 1'b1;
        end
      end

      MATCH_L, MATCH_R: begin
        state_d = state_q;
      end

      default: begin
        state_d = PLAY;
        pos_d   = POS_CENTRE;
      end
    endcase
  end

  // Output decode: playfield pattern and status flags from state and position.
  always_comb begin
    leds        = '0;
    round_win_l = 1'b0;
    round_win_r = 1'b0;
    match_over  = 1'b0;

    unique case (state_q)
      PLAY: begin
        leds = ONE_HOT_LSB << pos_q;
      end
      WIN_L: begin
        leds        = LEFT_HALF;
        round_win_l = 1'b1;
      end
      WIN_R: begin
        leds        = RIGHT_HALF;
        round_win_r = 1'b1;
      end
      MATCH_L: begin
        leds        = LEFT_HALF;
        round_win_l = 1'b1;
        match_over  = 1'b1;
      end
      MATCH_R: begin
        leds        = RIGHT_HALF;
        round_win_r = 1'b1;
        match_over  = 1'b1;
      end
      default: begin
        leds = '0;
      end
    endcase
  end

endmodule

// File: doc/tug_of_war_field.md
Name: tug_of_war_field

Overview:
- Parametrised tug-of-war playfield: a row of NUM_LIGHTS lights with exactly one lit at a time during play.
- Two players' button levels move the lit position one step per rising edge of their button.
- Pushing the light off either end wins the round for that player.
- The block keeps per-player scores, holds a win display, auto-restarts rounds, and latches a match winner; it sits between the debounced/synchronised button inputs and the LED/HEX display drivers.

Parameters:
NUM_LIGHTS, 9, number of lights; must be odd and >= 3; centre index C = (NUM_LIGHTS-1)/2.
WIN_SCORE, 7, round wins needed to take the match; 1..2^SCORE_W-1.
SCORE_W, 3, width of each score counter.
HOLD_CYCLES, 8, cycles the round-win display is held before the next round starts; >= 1.

Ports:
clk  input  1  system clock; all state updates on rising edge.
reset  input  1  asynchronous, active-high; returns the block to its reset state immediately.
L  input  1  left player button level (already synchronised); active-high.
R  input  1  right player button level (already synchronised); active-high.
leds  output  NUM_LIGHTS  playfield; bit NUM_LIGHTS-1 is leftmost, bit 0 is rightmost.
score_l  output  SCORE_W  left player rounds won.
score_r  output  SCORE_W  right player rounds won.
round_win_l  output  1  high while in WIN_L or MATCH_L.
round_win_r  output  1  high while in WIN_R or MATCH_R.
match_over  output  1  high in MATCH_L or MATCH_R.

Behaviour:
- Clock and reset: one clock (clk); reset asynchronous and active-high (reset).
- Reset values: state=PLAY, pos=C, leds=one-hot at C, scores=0, round_win_l=round_win_r=match_over=0, hold counter=0, edge registers cleared to 0.
  - A button held through reset deasserting does NOT produce a press.
- Edge detection: registered L_d, R_d.
  - pl = L & ~L_d; pr = R & ~R_d.
  - A held button yields exactly one press.
  - Edge registers update in every state.
- Move rule (PLAY only), evaluated in this order:
  - pl & pr in the same cycle: cancel, no move.
  - pl only, pos < NUM_LIGHTS-1: pos <= pos+1 (light moves left).
  - pl only, pos = NUM_LIGHTS-1: left wins the round.
  - pr only, pos > 0: pos <= pos-1.
  - pr only, pos = 0: right wins the round.
- Round win for player X:
  - score_X <= score_X+1.
  - If score_X+1 == WIN_SCORE, go to MATCH_X; otherwise go to WIN_X and load hold counter with HOLD_CYCLES-1.
- States:
  - PLAY: leds = one-hot(pos).
  - WIN_L: leds = all-ones in the left half (indices C+1..N-1), all others 0; presses ignored; hold counter decrements each cycle; at 0, next cycle: state=PLAY, pos=C. WIN_L therefore lasts exactly HOLD_CYCLES cycles.
  - WIN_R: mirror of WIN_L (indices 0..C-1).
  - MATCH_L / MATCH_R: leds as in the corresponding WIN state; scores frozen; presses ignored; terminal until reset.
- Latency: a press edge sampled at clock k is reflected on leds/scores after edge k (1-cycle registered); all outputs are driven from registers/state, with no combinational path from L/R.
- Score counters never wrap: they stop at WIN_SCORE by construction.
- Reset mid-round or mid-hold: immediate return to reset values; no score is retained.

Test Plan:
- NUM_LIGHTS=5, C=2: reset then release -> leds=5'b00100, scores 0, all flags 0.
- L rising edge ×2 (each pressed 1 cycle, released 1 cycle) -> leds 00100→01000→10000; third L edge -> score_l=1, round_win_l=1, leds=11000 for exactly HOLD_CYCLES=8 cycles, then leds=00100, round_win_l=0.
- L held high 10 cycles from centre -> single move only, leds=01000; L and R rising in the same cycle -> leds unchanged.
- pos=0 (leds=00001), R edge -> score_r=1, leds=00011 held 8 cycles; L/R edges during the hold -> ignored, score unchanged, restart at 00100.
- WIN_SCORE=2: two left round wins -> after the second, match_over=1, round_win_l=1, score_l=2, leds=11000 constant for 50 cycles despite presses; assert reset -> all outputs return to reset values asynchronously, before the next clk edge.
- Assert reset during the WIN_R hold (counter=3) -> leds=00100, score_r=0 immediately; after release, R held high through reset produces no move.
